// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_ctrl
//  Description : Bit-serial a - b - bin using one time-shared full-subtractor
//                slice, LSB first, with valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int              c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    // Only WIDTH-1 result bits need storage; the last bit goes straight to diff.
    logic [WIDTH-2:0] r_sr;
    logic             r_br;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_d;
    logic             w_bnext;
    logic [WIDTH-1:0] w_sr_next;

    assign w_d       = r_sa[0] ^ r_sb[0] ^ r_br;
    assign w_bnext   = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    assign w_sr_next = {w_d, r_sr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sa <= r_sa >> 1;
                    r_sb <= r_sb >> 1;
                    r_sr <= w_sr_next[WIDTH-1:1];
                    r_br <= w_bnext;
                    if (r_cnt == c_LAST) begin
                        r_diff   <= w_sr_next;
                        r_borrow <= w_bnext;
                        r_cnt    <= '0;
                        r_state  <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == c_IDLE);
    assign out_valid  = (r_state == c_DONE);
    assign busy       = (r_state == c_RUN) || (r_state == c_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_ctrl
//  Description : Self-checking bench for serial_subtractor_ctrl (WIDTH 8 and 4)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, bin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, borrow8, busy8;
    logic [7:0] diff8;

    logic       in_valid4 = 1'b0, out_ready4 = 1'b0, bin4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       in_ready4, out_valid4, borrow4, busy4;
    logic [3:0] diff4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .borrow_out(borrow8), .busy(busy8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .borrow_out(borrow4), .busy(busy4)
    );

    // Arithmetic reference: plain integer subtraction, reduced mod 2^w.
    function automatic int ref_diff(input int ra, input int rb, input int rbin, input int w);
        return (ra - rb - rbin) & ((1 << w) - 1);
    endfunction

    function automatic logic ref_borrow(input int ra, input int rb, input int rbin);
        return (ra < rb + rbin);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts one WIDTH=8 op from IDLE and waits (bounded) for out_valid.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_in, input logic tbin,
                        output int lat, output int busyc);
        a8 = ta; b8 = tb_in; bin8 = tbin; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        lat   = 0;
        busyc = busy8 ? 1 : 0;
        while (!out_valid8 && lat < 40) begin
            step();
            lat++;
            if (busy8) busyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready8); end
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid8); end
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        total++; if ({borrow8, diff8} !== 9'h000) begin bad++; $display("FAIL reset_result got=%h exp=000", {borrow8, diff8}); end
        total++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin bad++; $display("FAIL reset_w4 got=%b%b exp=10", in_ready4, out_valid4); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat, bc;
        run8(8'h5A, 8'h23, 1'b0, lat, bc);
        total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        total++; if (diff8 !== 8'h37) begin bad++; $display("FAIL basic_diff got=%h exp=37", diff8); end
        total++; if (borrow8 !== 1'b0) begin bad++; $display("FAIL basic_borrow got=%b exp=0", borrow8); end
        step();
        total++; if (bc !== 9) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=9", bc); end
        total++; if (busy8 !== 1'b0 || in_ready8 !== 1'b1) begin bad++; $display("FAIL basic_idle got busy=%b in_ready=%b exp busy=0 in_ready=1", busy8, in_ready8); end
        total++; if (diff8 !== 8'h37) begin bad++; $display("FAIL basic_diff_hold got=%h exp=37", diff8); end
    endtask

    task automatic test_borrow();
        int lat, bc;
        logic [8:0] exp_v [3];
        logic [16:0] ops [3];
        ops[0] = {8'h00, 8'h01, 1'b0}; exp_v[0] = {1'b1, 8'hFF};
        ops[1] = {8'h10, 8'h10, 1'b1}; exp_v[1] = {1'b1, 8'hFF};
        ops[2] = {8'h80, 8'h7F, 1'b1}; exp_v[2] = {1'b0, 8'h00};
        for (int i = 0; i < 3; i++) begin
            run8(ops[i][16:9], ops[i][8:1], ops[i][0], lat, bc);
            total++;
            if ({borrow8, diff8} !== exp_v[i]) begin
                bad++; $display("FAIL borrow_case%0d got=%h exp=%h", i, {borrow8, diff8}, exp_v[i]);
            end
            step();
        end
    endtask

    task automatic test_random8();
        int lat, bc, ra, rb, rbin;
        for (int i = 0; i < 16; i++) begin
            ra = int'($urandom_range(0, 255)); rb = int'($urandom_range(0, 255)); rbin = int'($urandom_range(0, 1));
            run8(8'(ra), 8'(rb), 1'(rbin), lat, bc);
            total++;
            if (lat !== 8 || int'(diff8) !== ref_diff(ra, rb, rbin, 8) || borrow8 !== ref_borrow(ra, rb, rbin)) begin
                bad++; $display("FAIL random8 a=%0d b=%0d bin=%0d got lat=%0d diff=%0d bo=%b exp lat=8 diff=%0d bo=%b",
                                ra, rb, rbin, lat, diff8, borrow8, ref_diff(ra, rb, rbin, 8), ref_borrow(ra, rb, rbin));
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int w;
        logic [7:0] ed;
        logic eb;
        ed = 8'(ref_diff(8'hC3, 8'h5E, 1, 8));
        eb = ref_borrow(8'hC3, 8'h5E, 1);
        a8 = 8'hC3; b8 = 8'h5E; bin8 = 1'b1; in_valid8 = 1'b1; out_ready8 = 1'b0;
        step();
        w = 0;
        while (!out_valid8 && w < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            step();
            w++;
        end
        total++; if (w !== 8) begin bad++; $display("FAIL bp_latency got=%0d exp=8", w); end
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
            step();
            total++;
            if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || diff8 !== ed || borrow8 !== eb) begin
                bad++; $display("FAIL bp_hold cyc=%0d got ov=%b ir=%b diff=%h bo=%b exp ov=1 ir=0 diff=%h bo=%b",
                                i, out_valid8, in_ready8, diff8, borrow8, ed, eb);
            end
        end
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        step();
        total++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || diff8 !== ed) begin
            bad++; $display("FAIL bp_release got ir=%b ov=%b diff=%h exp ir=1 ov=0 diff=%h", in_ready8, out_valid8, diff8, ed);
        end
    endtask

    task automatic test_reset_midrun();
        int lat, bc;
        a8 = 8'hE7; b8 = 8'h12; bin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
        step();
        in_valid8 = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        total++;
        if (out_valid8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== 8'h00 || in_ready8 !== 1'b1 || borrow8 !== 1'b0) begin
            bad++; $display("FAIL abort got ov=%b busy=%b diff=%h ir=%b bo=%b exp ov=0 busy=0 diff=00 ir=1 bo=0",
                            out_valid8, busy8, diff8, in_ready8, borrow8);
        end
        step();
        rst = 1'b0;
        run8(8'h05, 8'h03, 1'b0, lat, bc);
        total++;
        if (lat !== 8 || diff8 !== 8'h02 || borrow8 !== 1'b0) begin
            bad++; $display("FAIL post_reset_op got lat=%0d diff=%h bo=%b exp lat=8 diff=02 bo=0", lat, diff8, borrow8);
        end
        step();
    endtask

    task automatic test_exhaustive4();
        logic [4:0] q [$];
        logic [4:0] ev;
        logic [8:0] idx;
        int sent = 0, recv = 0, cyc = 0;
        in_valid4 = 1'b0; out_ready4 = 1'b0;
        while (recv < 512 && cyc < 30000) begin
            @(negedge clk);
            if (out_valid4 && out_ready4) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL ex4_unexpected got diff=%h bo=%b exp none", diff4, borrow4);
                end else begin
                    ev = q.pop_front();
                    if ({borrow4, diff4} !== ev) begin
                        bad++; $display("FAIL ex4_result n=%0d got=%h exp=%h", recv, {borrow4, diff4}, ev);
                    end
                end
                recv++;
            end
            if (in_valid4 && in_ready4) begin
                q.push_back({ref_borrow(int'(a4), int'(b4), int'(bin4)),
                             4'(ref_diff(int'(a4), int'(b4), int'(bin4), 4))});
                sent++;
            end
            step();
            cyc++;
            if (sent < 512 && $urandom_range(0, 3) != 0) begin
                idx = 9'(sent);
                in_valid4 = 1'b1;
                {a4, b4, bin4} = idx;
            end else begin
                in_valid4 = 1'b0;
                {a4, b4, bin4} = 9'($urandom);
            end
            out_ready4 = ($urandom_range(0, 2) != 0);
        end
        total++;
        if (recv !== 512 || sent !== 512 || q.size() !== 0) begin
            bad++; $display("FAIL ex4_count got sent=%0d recv=%0d pending=%0d exp 512/512/0", sent, recv, q.size());
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if (out_valid4 !== 1'b0) begin bad++; $display("FAIL ex4_duplicate cyc=%0d got ov=%b exp 0", i, out_valid4); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_random8();
        test_backpressure();
        test_reset_midrun();
        test_exhaustive4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
